// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline control for a five-stage Y86-style core.
// Detects load-use, ret and branch-mispredict hazards and drives the
// stall/bubble controls of the F, D, E, M and W pipe registers. A memory-stage
// error drains the pipe. A writeback error halts it until reset.
// Optional build macro: PIPE_CTRL_PERF_EN adds the saturating 32-bit counters
// stall_cnt, bubble_cnt and mispred_cnt.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  E_dstM,
    input  logic        e_Cnd,
    input  logic [2:0]  m_stat,
    input  logic [2:0]  W_stat,
    output logic        F_stall,
    output logic        D_stall,
    output logic        W_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        halted,
    output logic [2:0]  halt_stat
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt,
    output logic [31:0] mispred_cnt
`endif
);

    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;
    localparam logic [3:0] REG_NONE     = 4'hF;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t state;
    state_t nextState;

    logic loadUse;
    logic retPend;
    logic mispred;
    logic exc;

    logic runFStall;
    logic runDStall;
    logic runWStall;
    logic runDBubble;
    logic runEBubble;
    logic runMBubble;

    // Hazard detection from the current pipe-register contents
    always_comb begin
        loadUse = ((E_icode == ICODE_MRMOVQ) || (E_icode == ICODE_POPQ)) &&
                  (E_dstM != REG_NONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        retPend = (D_icode == ICODE_RET) || (E_icode == ICODE_RET) ||
                  (M_icode == ICODE_RET);
        mispred = (E_icode == ICODE_JXX) && !e_Cnd;
        exc     = (m_stat == STAT_HLT) || (m_stat == STAT_ADR) || (m_stat == STAT_INS) ||
                  (W_stat == STAT_HLT) || (W_stat == STAT_ADR) || (W_stat == STAT_INS);
    end

    // Control equations used while the pipe is running normally
    always_comb begin
        runFStall  = loadUse || retPend;
        // A mispredict squashes the decode slot, so it overrides the load-use hold
        runDStall  = loadUse && !mispred;
        runDBubble = mispred || (retPend && !loadUse);
        runEBubble = mispred || loadUse;
        runMBubble = exc;
        runWStall  = (W_stat != STAT_AOK);
    end

    // State register; halt_stat captures the status that stopped the pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            halt_stat <= '0;
        end else begin
            state <= nextState;
            if ((state != HALTED) && (nextState == HALTED)) begin
                halt_stat <= W_stat;
            end
        end
    end

    // Next state: a writeback error halts, a memory-stage error drains first
    always_comb begin
        nextState = state;
        case (state)
            RUN: begin
                if (W_stat != STAT_AOK) begin
                    nextState = HALTED;
                end else if (m_stat != STAT_AOK) begin
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (W_stat != STAT_AOK) begin
                    nextState = HALTED;
                end
            end
            HALTED: nextState = HALTED;
            default: nextState = RUN;
        endcase
    end

    // Output decode; an asserted reset flushes the pipe regardless of state
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        halted   = 1'b0;
        if (!rst_n) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    F_stall  = runFStall;
                    D_stall  = runDStall;
                    W_stall  = runWStall;
                    D_bubble = runDBubble;
                    E_bubble = runEBubble;
                    M_bubble = runMBubble;
                end
                DRAIN: begin
                    F_stall  = 1'b1;
                    D_bubble = 1'b1;
                    E_bubble = 1'b1;
                    M_bubble = 1'b1;
                end
                HALTED: begin
                    F_stall = 1'b1;
                    D_stall = 1'b1;
                    W_stall = 1'b1;
                    halted  = 1'b1;
                end
                default: begin
                    D_bubble = 1'b1;
                    E_bubble = 1'b1;
                    M_bubble = 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Saturating event counters, advancing only while the pipe is running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            bubble_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (state == RUN) begin
            if (runFStall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (runDBubble && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
            if (mispred && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
